// File: rtl/pc_next_unit.sv
// Registered fetch-stage program counter with sequential, branch, jump, register-jump
// and exception targets, plus an optional one-fetch branch-delay-slot deferral.
module pc_next_unit #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       REGION_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(32'h0040_0000),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h8000_0180),
  parameter bit                DELAY_SLOT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_i,
  input  logic                         branch_taken_i,
  input  logic [15:0]                  imm_i,
  input  logic                         jump_i,
  input  logic [ADDR_W-REGION_W-3:0]   index_i,
  input  logic                         jr_i,
  input  logic [ADDR_W-1:0]            reg_target_i,
  input  logic                         exception_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic [ADDR_W-1:0]            pc_plus4_o,
  output logic                         pending_o,
  output logic                         misaligned_o
);

  localparam int unsigned IDX_W = ADDR_W - REGION_W - 2;

  typedef enum logic {IDLE, SLOT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic                mis_q, mis_d;
  logic [ADDR_W-1:0]   jump_tgt, branch_tgt, jr_tgt, target;
  logic [IDX_W-1:0]    index;
  logic                redirect;

  assign index      = index_i;
  assign pc_plus4_o = pc_q + ADDR_W'(4);

  // Candidate targets; the branch offset is a signed word count.
  assign jump_tgt   = {pc_plus4_o[ADDR_W-1 -: REGION_W], index, 2'b00};
  assign branch_tgt = pc_plus4_o + ADDR_W'($signed({imm_i, 2'b00}));
  assign jr_tgt     = {reg_target_i[ADDR_W-1:2], 2'b00};
  assign redirect   = jr_i | jump_i | branch_taken_i;

  always_comb begin
    target = branch_tgt;
    if (jr_i)        target = jr_tgt;
    else if (jump_i) target = jump_tgt;
  end

  // Next-state: exception beats stall, stall freezes everything else.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    tgt_d   = tgt_q;
    mis_d   = 1'b0;
    if (exception_i) begin
      pc_d    = EXC_VECTOR;
      state_d = IDLE;
      tgt_d   = '0;
    end else if (!stall_i) begin
      if (state_q == SLOT) begin
        pc_d    = tgt_q;
        state_d = IDLE;
      end else begin
        mis_d = jr_i & (reg_target_i[1:0] != 2'b00);
        if (!redirect) begin
          pc_d = pc_plus4_o;
        end else if (DELAY_SLOT) begin
          pc_d    = pc_plus4_o;
          tgt_d   = target;
          state_d = SLOT;
        end else begin
          pc_d = target;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = mis_q;
  assign pending_o    = DELAY_SLOT & (state_q == SLOT);

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a delay-slot and an immediate-redirect instance driven
// with the same inputs, each checked against a plain-arithmetic PC model.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br, jump, jr, exc;
  logic [15:0] imm;
  logic [25:0] index;
  logic [31:0] rt;

  logic [31:0] pc1, pp1, pc0, pp0;
  logic        pend1, mis1, pend0, mis0;

  int total = 0;
  int bad   = 0;

  // Model of the delay-slot build (m1_*) and the immediate build (m0_*).
  logic [31:0] m1_pc, m1_tgt, m0_pc;
  bit          m1_slot, m1_mis, m0_mis;

  always #5 clk = ~clk;

  pc_next_unit #(.DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(br), .imm_i(imm),
    .jump_i(jump), .index_i(index), .jr_i(jr), .reg_target_i(rt), .exception_i(exc),
    .pc_o(pc1), .pc_plus4_o(pp1), .pending_o(pend1), .misaligned_o(mis1));

  pc_next_unit #(.DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(br), .imm_i(imm),
    .jump_i(jump), .index_i(index), .jr_i(jr), .reg_target_i(rt), .exception_i(exc),
    .pc_o(pc0), .pc_plus4_o(pp0), .pending_o(pend0), .misaligned_o(mis0));

  function automatic logic [31:0] target_of(input logic [31:0] p4);
    int off;
    if (jr)   return rt & 32'hFFFF_FFFC;
    if (jump) return (p4 & 32'hF000_0000) | ({6'b0, index} << 2);
    off = int'($signed(imm)) * 4;
    return p4 + 32'(off);
  endfunction

  task automatic clear_in();
    stall = 0; br = 0; jump = 0; jr = 0; exc = 0;
    imm = '0; index = '0; rt = '0;
  endtask

  task automatic model_reset();
    m1_pc = 32'h0040_0000; m1_tgt = '0; m1_slot = 0; m1_mis = 0;
    m0_pc = 32'h0040_0000; m0_mis = 0;
  endtask

  // Advance one clock edge, updating the model from the inputs currently applied.
  task automatic step();
    logic [31:0] n1_pc, n1_tgt, n0_pc;
    bit n1_slot, n1_mis, n0_mis, any;
    any = jr | jump | br;
    n1_pc = m1_pc; n1_tgt = m1_tgt; n1_slot = m1_slot; n1_mis = 0;
    n0_pc = m0_pc; n0_mis = 0;
    if (exc) begin
      n1_pc = 32'h8000_0180; n1_slot = 0; n1_tgt = '0;
      n0_pc = 32'h8000_0180;
    end else if (!stall) begin
      if (m1_slot) begin
        n1_pc = m1_tgt; n1_slot = 0;
      end else begin
        n1_mis = jr && (rt[1:0] != 2'b00);
        n1_pc  = m1_pc + 32'd4;
        if (any) begin n1_slot = 1; n1_tgt = target_of(m1_pc + 32'd4); end
      end
      n0_mis = jr && (rt[1:0] != 2'b00);
      n0_pc  = any ? target_of(m0_pc + 32'd4) : m0_pc + 32'd4;
    end
    @(posedge clk); #1;
    m1_pc = n1_pc; m1_tgt = n1_tgt; m1_slot = n1_slot; m1_mis = n1_mis;
    m0_pc = n0_pc; m0_mis = n0_mis;
  endtask

  task automatic test_reset();
    clear_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++; if (pc1 !== 32'h0040_0000) begin bad++; $display("FAIL reset_pc1: got %h want %h", pc1, 32'h0040_0000); end
    total++; if (pc0 !== 32'h0040_0000) begin bad++; $display("FAIL reset_pc0: got %h want %h", pc0, 32'h0040_0000); end
    total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b want 0", pend1); end
    total++; if (mis1 !== 1'b0 || mis0 !== 1'b0) begin bad++; $display("FAIL reset_misaligned: got %b/%b want 0/0", mis1, mis0); end
    rst_n = 1;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      step();
      total++; if (pc1 !== 32'h0040_0000 + 32'(4 * i)) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", i, pc1, 32'h0040_0000 + 32'(4 * i)); end
      total++; if (pend1 !== 1'b0) begin bad++; $display("FAIL seq_pending%0d: got %b want 0", i, pend1); end
    end
    total++; if (pp1 !== 32'h0040_0010) begin bad++; $display("FAIL seq_plus4: got %h want %h", pp1, 32'h0040_0010); end
  endtask

  task automatic test_delay_jump();
    step();
    total++; if (pc1 !== 32'h0040_0010) begin bad++; $display("FAIL dj_start: got %h want %h", pc1, 32'h0040_0010); end
    jump = 1; index = 26'h0100040;
    step();
    clear_in();
    total++; if (pc1 !== 32'h0040_0014 || pend1 !== 1'b1) begin bad++; $display("FAIL dj_slot: got %h/%b want %h/1", pc1, pend1, 32'h0040_0014); end
    total++; if (pc0 !== 32'h0040_0100 || pend0 !== 1'b0) begin bad++; $display("FAIL dj_nods: got %h/%b want %h/0", pc0, pend0, 32'h0040_0100); end
    step();
    total++; if (pc1 !== 32'h0040_0100 || pend1 !== 1'b0) begin bad++; $display("FAIL dj_target: got %h/%b want %h/0", pc1, pend1, 32'h0040_0100); end
  endtask

  task automatic test_branch_nods();
    test_reset();
    repeat (8) step();
    total++; if (pc0 !== 32'h0040_0020) begin bad++; $display("FAIL br_start: got %h want %h", pc0, 32'h0040_0020); end
    br = 1; imm = 16'hFFFC;
    step();
    clear_in();
    total++; if (pc0 !== 32'h0040_0014) begin bad++; $display("FAIL br_back: got %h want %h", pc0, 32'h0040_0014); end
    total++; if (pc1 !== 32'h0040_0024 || pend1 !== 1'b1) begin bad++; $display("FAIL br_ds_slot: got %h/%b want %h/1", pc1, pend1, 32'h0040_0024); end
    step();
    total++; if (pc1 !== 32'h0040_0014) begin bad++; $display("FAIL br_ds_target: got %h want %h", pc1, 32'h0040_0014); end
  endtask

  task automatic test_misaligned_jr();
    logic [31:0] held;
    jr = 1; rt = 32'h0040_1003;
    step();
    clear_in();
    held = m1_pc;
    total++; if (mis1 !== 1'b1 || pend1 !== 1'b1) begin bad++; $display("FAIL jr_accept: got mis=%b pend=%b want 1/1", mis1, pend1); end
    total++; if (pc0 !== 32'h0040_1000 || mis0 !== 1'b1) begin bad++; $display("FAIL jr_nods: got %h/%b want %h/1", pc0, mis0, 32'h0040_1000); end
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (pc1 !== held || pend1 !== 1'b1 || mis1 !== 1'b0) begin bad++; $display("FAIL jr_stall%0d: got %h/%b/%b want %h/1/0", i, pc1, pend1, mis1, held); end
    end
    stall = 0;
    step();
    total++; if (pc1 !== 32'h0040_1000 || pend1 !== 1'b0) begin bad++; $display("FAIL jr_target: got %h/%b want %h/0", pc1, pend1, 32'h0040_1000); end
  endtask

  task automatic test_exception();
    jump = 1; index = 26'h0000100;
    step();
    clear_in();
    total++; if (pend1 !== 1'b1) begin bad++; $display("FAIL exc_enter_slot: got %b want 1", pend1); end
    stall = 1; exc = 1; jump = 1; index = 26'h0000200;
    step();
    clear_in();
    total++; if (pc1 !== 32'h8000_0180 || pend1 !== 1'b0) begin bad++; $display("FAIL exc_vector: got %h/%b want %h/0", pc1, pend1, 32'h8000_0180); end
    total++; if (pc0 !== 32'h8000_0180) begin bad++; $display("FAIL exc_vector_nods: got %h want %h", pc0, 32'h8000_0180); end
    step();
    total++; if (pc1 !== 32'h8000_0184) begin bad++; $display("FAIL exc_no_old_target: got %h want %h", pc1, 32'h8000_0184); end
  endtask

  task automatic test_async_reset();
    jump = 1; index = 26'h0000300;
    step();
    clear_in();
    total++; if (pend1 !== 1'b1) begin bad++; $display("FAIL ar_enter_slot: got %b want 1", pend1); end
    #3 rst_n = 0;
    #1;
    total++; if (pc1 !== 32'h0040_0000 || pend1 !== 1'b0) begin bad++; $display("FAIL ar_immediate: got %h/%b want %h/0", pc1, pend1, 32'h0040_0000); end
    total++; if (pc0 !== 32'h0040_0000) begin bad++; $display("FAIL ar_immediate_nods: got %h want %h", pc0, 32'h0040_0000); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    step();
    total++; if (pc1 !== 32'h0040_0004 || pend1 !== 1'b0) begin bad++; $display("FAIL ar_release: got %h/%b want %h/0", pc1, pend1, 32'h0040_0004); end
  endtask

  task automatic test_wrap();
    jr = 1; rt = 32'hFFFF_FFFC;
    step();
    clear_in();
    total++; if (pc0 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load: got %h want %h", pc0, 32'hFFFF_FFFC); end
    total++; if (pp0 !== 32'h0000_0000) begin bad++; $display("FAIL wrap_plus4: got %h want 00000000", pp0); end
    step();
    total++; if (pc0 !== 32'h0000_0000) begin bad++; $display("FAIL wrap_pc: got %h want 00000000", pc0); end
    step();
    total++; if (pc1 !== m1_pc) begin bad++; $display("FAIL wrap_ds_pc: got %h want %h", pc1, m1_pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom % 4) == 0;
      exc   = ($urandom % 20) == 0;
      jr    = ($urandom % 8) == 0;
      jump  = ($urandom % 8) == 0;
      br    = ($urandom % 6) == 0;
      imm   = 16'($urandom);
      index = 26'($urandom);
      rt    = $urandom;
      step();
      total++; if (pc1 !== m1_pc) begin bad++; $display("FAIL rnd_pc1 cyc%0d: got %h want %h", i, pc1, m1_pc); end
      total++; if (pend1 !== m1_slot) begin bad++; $display("FAIL rnd_pend1 cyc%0d: got %b want %b", i, pend1, m1_slot); end
      total++; if (mis1 !== m1_mis) begin bad++; $display("FAIL rnd_mis1 cyc%0d: got %b want %b", i, mis1, m1_mis); end
      total++; if (pp1 !== m1_pc + 32'd4) begin bad++; $display("FAIL rnd_pp1 cyc%0d: got %h want %h", i, pp1, m1_pc + 32'd4); end
      total++; if (pc0 !== m0_pc) begin bad++; $display("FAIL rnd_pc0 cyc%0d: got %h want %h", i, pc0, m0_pc); end
      total++; if (mis0 !== m0_mis || pend0 !== 1'b0) begin bad++; $display("FAIL rnd_flags0 cyc%0d: got %b/%b want %b/0", i, mis0, pend0, m0_mis); end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_delay_jump();
    test_branch_nods();
    test_misaligned_jr();
    test_exception();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Registered program-counter / next-PC generator for the MIPS CPU fetch stage. It generalises the fixed 28+4-bit jump-address concatenation into a parametrised target unit. The unit computes sequential, branch, jump, register-jump and exception targets, and holds the PC under stall. An optional branch-delay-slot state machine defers the redirect by one fetch.

## Interface
Parameters:
- ADDR_W, 32, PC/address width (≥ 8)
- REGION_W, 4, upper PC bits kept from PC+4 on a J-type jump; jump index width is ADDR_W-REGION_W-2
- RESET_PC, 32'h0040_0000, PC value after reset (low 2 bits must be 0)
- EXC_VECTOR, 32'h8000_0180, PC loaded on exception
- DELAY_SLOT, 1, 1 = MIPS delay-slot semantics, 0 = immediate redirect

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, asynchronous and active-low
- stall_i  in  1  hold PC and state
- branch_taken_i  in  1  taken conditional branch at pc_o
- imm_i  in  16  branch offset in words, signed
- jump_i  in  1  J/JAL at pc_o
- index_i  in  ADDR_W-REGION_W-2  jump word index
- jr_i  in  1  JR/JALR at pc_o
- reg_target_i  in  ADDR_W  register jump target
- exception_i  in  1  exception request
- pc_o  out  ADDR_W  current fetch PC, registered
- pc_plus4_o  out  ADDR_W  pc_o+4, combinational, wraps modulo 2^ADDR_W
- pending_o  out  1  registered; high while in SLOT
- misaligned_o  out  1  registered one-cycle pulse on JR target with bits [1:0] ≠ 0

## Operation
- Target arithmetic, all modulo 2^ADDR_W:
  - jump = {pc_plus4_o[ADDR_W-1 -: REGION_W], index_i, 2'b00}
  - branch = pc_plus4_o + (sign-extend(imm_i) << 2)
  - jr = {reg_target_i[ADDR_W-1:2], 2'b00}
- Priority: exception_i > jr_i > jump_i > branch_taken_i. Lower-priority requests in the same cycle are discarded.
- States: IDLE, SLOT. SLOT exists only when DELAY_SLOT=1; with DELAY_SLOT=0, pending_o is tied 0.
- IDLE, no stall:
  - No redirect: pc_o ← pc_plus4_o.
  - Redirect, DELAY_SLOT=1: pc_o ← pc_plus4_o (the delay slot), target_q ← target, go to SLOT.
  - Redirect, DELAY_SLOT=0: pc_o ← target.
- SLOT, no stall: pc_o ← target_q, go to IDLE. Branch, jump and jr inputs in SLOT are ignored; a branch in a delay slot is unsupported.
- Stall (exception_i low): pc_o, state, target_q and all inputs are ignored and held; misaligned_o ← 0.
- Exception: overrides stall and any state. pc_o ← EXC_VECTOR, state ← IDLE, pending target is dropped.
- misaligned_o ← 1 for one cycle when an accepted jr has reg_target_i[1:0] ≠ 0. It is not raised if the jr is stalled or pre-empted by an exception. The PC still redirects to the forced-aligned target.

## Timing
- Reset (asynchronous assert, synchronous release on next clk edge):
  - pc_o = RESET_PC, state = IDLE, target_q = 0, pending_o = 0, misaligned_o = 0.
  - Reset asserted mid-SLOT discards the pending target.
- Redirect latency:
  - DELAY_SLOT=1: target appears on pc_o 2 unstalled edges after the request cycle.
  - DELAY_SLOT=0: 1 edge.
  - Exception: 1 edge, regardless of stall.
- pending_o rises on the edge entering SLOT and falls on the edge leaving it.
- Stall cycles in SLOT extend SLOT; the target is preserved.
- PC wrap: pc_o = 2^ADDR_W-4 with no redirect → 0 on the next edge.

## Test plan
- Reset, sequential run: release rst_n, 3 unstalled cycles → pc_o 0x00400000, 0x00400004, 0x00400008, 0x0040000C; pending_o = 0.
- Delay-slot jump: pc_o = 0x00400010, jump_i = 1, index_i = 0x0100040 → next pc_o 0x00400014 with pending_o = 1, then 0x00400100 with pending_o = 0.
- Backward branch, DELAY_SLOT=0 build: pc_o = 0x00400020, branch_taken_i = 1, imm_i = 16'hFFFC → next pc_o 0x00400014.
- Misaligned JR with stall in SLOT: jr_i = 1, reg_target_i = 0x00401003 → misaligned_o pulses 1 cycle. stall_i high 2 cycles in SLOT keeps pending_o = 1 and pc_o unchanged. Then pc_o = 0x00401000.
- Exception priority: in SLOT with stall_i = 1, assert exception_i together with jump_i → next pc_o 0x80000180, pending_o = 0. Old target is never fetched.
- Async reset mid-SLOT: drop rst_n between edges → pc_o = 0x00400000 and pending_o = 0 immediately, without waiting for a clk edge.
